// File: rtl/alien_formation_ctrl.sv
// Alien formation origin sequencer: march, edge drop/reverse,
// kill-driven speed-up, landing and defeat halt.
module alien_formation_ctrl #(
   parameter int SCREEN_W  = 640,
   parameter int ALIEN_W   = 30,
   parameter int ALIEN_WS  = 10,
   parameter int ALIEN_H   = 20,
   parameter int ALIEN_HS  = 10,
   parameter int NUM_COLS  = 10,
   parameter int NUM_ROWS  = 5,
   parameter int STEP_X    = 10,
   parameter int STEP_Y    = 10,
   parameter int START_ROW = 40,
   parameter int START_COL = 100,
   parameter int MIN_TICKS = 2,
   parameter int LAND_ROW  = 400
) (
   input  logic                         Clk,
   input  logic                         Reset_N,
   input  logic                         Game_Start,
   input  logic                         Frame_Tick,
   input  logic [NUM_ROWS*NUM_COLS-1:0] Aliens_Grid,
   input  logic                         Aliens_Defeated,
   output logic [8:0]                   Aliens_Row,
   output logic [9:0]                   Aliens_Col,
   output logic                         Direction,
   output logic                         Step_Pulse,
   output logic                         Aliens_Landed,
   output logic [1:0]                   Ctrl_State
);

   localparam int COL_PITCH = ALIEN_W + ALIEN_WS;
   localparam int ROW_PITCH = ALIEN_H + ALIEN_HS;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MARCH = 2'b01,
      DROP  = 2'b10,
      HALT  = 2'b11
   } state_e;

   state_e      state_q;
   logic [8:0]  row_q;
   logic [9:0]  col_q;
   logic        dir_q;
   logic        pulse_q;
   logic        landed_q;
   logic [5:0]  cnt_q;

   logic [NUM_COLS-1:0] col_any;
   logic [NUM_ROWS-1:0] row_any;
   logic [5:0]  live_cnt;
   logic [3:0]  l_idx;
   logic [3:0]  r_idx;
   logic [2:0]  b_idx;
   logic [10:0] right_edge;
   logic [10:0] left_edge;
   logic [9:0]  bottom;
   logic [5:0]  interval;
   logic        any_live;
   logic        landing;
   logic        step_due;
   logic        hit_right;
   logic        hit_left;

   // Occupancy summary of the live grid: population, outer columns, lowest row
   always_comb begin
      col_any  = '0;
      row_any  = '0;
      live_cnt = '0;
      l_idx    = '0;
      r_idx    = '0;
      b_idx    = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            if (Aliens_Grid[r*NUM_COLS+c]) begin
               col_any[c] = 1'b1;
               row_any[r] = 1'b1;
               live_cnt   = live_cnt + 6'd1;
            end
         end
      end
      for (int c = NUM_COLS-1; c >= 0; c--) begin
         if (col_any[c]) l_idx = 4'(c);
      end
      for (int c = 0; c < NUM_COLS; c++) begin
         if (col_any[c]) r_idx = 4'(c);
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (row_any[r]) b_idx = 3'(r);
      end
   end

   // Pixel extents of the live block and step/edge/landing decisions
   always_comb begin
      right_edge = {1'b0, col_q} + 11'(r_idx) * 11'(COL_PITCH)
                 + 11'(ALIEN_W);
      left_edge  = {1'b0, col_q} + 11'(l_idx) * 11'(COL_PITCH);
      bottom     = {1'b0, row_q} + 10'(b_idx) * 10'(ROW_PITCH)
                 + 10'(ALIEN_H);
      interval   = 6'(MIN_TICKS) + (live_cnt >> 1);
      any_live   = |Aliens_Grid;
      landing    = any_live && (bottom >= 10'(LAND_ROW));
      step_due   = Frame_Tick && any_live && ((cnt_q + 6'd1) >= interval);
      hit_right  = (right_edge + 11'(STEP_X)) > 11'(SCREEN_W);
      hit_left   = left_edge < 11'(STEP_X);
   end

   // Formation controller: origin, direction, tick counter, status flags
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q  <= IDLE;
         row_q    <= 9'(START_ROW);
         col_q    <= 10'(START_COL);
         dir_q    <= 1'b1;
         pulse_q  <= 1'b0;
         landed_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pulse_q <= 1'b0;
         if (Game_Start) begin
            state_q  <= MARCH;
            row_q    <= 9'(START_ROW);
            col_q    <= 10'(START_COL);
            dir_q    <= 1'b1;
            landed_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            unique case (state_q)
               IDLE: ;
               MARCH: begin
                  if (Aliens_Defeated) begin
                     state_q <= HALT;
                  end else if (landing) begin
                     state_q  <= HALT;
                     landed_q <= 1'b1;
                  end else if (step_due) begin
                     cnt_q <= '0;
                     if (dir_q ? hit_right : hit_left) begin
                        state_q <= DROP;
                     end else begin
                        col_q   <= dir_q ? col_q + 10'(STEP_X)
                                         : col_q - 10'(STEP_X);
                        pulse_q <= 1'b1;
                     end
                  end else if (Frame_Tick && any_live) begin
                     cnt_q <= cnt_q + 6'd1;
                  end
               end
               DROP: begin
                  if (Aliens_Defeated) begin
                     state_q <= HALT;
                  end else if (landing) begin
                     state_q  <= HALT;
                     landed_q <= 1'b1;
                  end else begin
                     row_q   <= row_q + 9'(STEP_Y);
                     dir_q   <= ~dir_q;
                     cnt_q   <= '0;
                     pulse_q <= 1'b1;
                     state_q <= MARCH;
                  end
               end
               HALT: ;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign Aliens_Row    = row_q;
   assign Aliens_Col    = col_q;
   assign Direction     = dir_q;
   assign Step_Pulse    = pulse_q;
   assign Aliens_Landed = landed_q;
   assign Ctrl_State    = state_q;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Scoreboard bench for alien_formation_ctrl: a pixel-level
// reference model predicts every origin update and flag.
module tb_alien_formation_ctrl;

   localparam logic [49:0] FULL = '1;

   typedef struct packed {
      logic [8:0] row;
      logic [9:0] col;
      logic       dir;
      logic [1:0] st;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset_N = 1'b0;
   logic        Game_Start = 1'b0;
   logic        Frame_Tick = 1'b0;
   logic [49:0] Aliens_Grid = '0;
   logic        Aliens_Defeated = 1'b0;
   logic [8:0]  Aliens_Row;
   logic [9:0]  Aliens_Col;
   logic        Direction;
   logic        Step_Pulse;
   logic        Aliens_Landed;
   logic [1:0]  Ctrl_State;

   int nchk = 0;
   int nerr = 0;
   exp_t exp_q[$];

   int m_row, m_col, m_dir, m_mode, m_cnt, m_landed;

   alien_formation_ctrl dut (
      .Clk(Clk),
      .Reset_N(Reset_N),
      .Game_Start(Game_Start),
      .Frame_Tick(Frame_Tick),
      .Aliens_Grid(Aliens_Grid),
      .Aliens_Defeated(Aliens_Defeated),
      .Aliens_Row(Aliens_Row),
      .Aliens_Col(Aliens_Col),
      .Direction(Direction),
      .Step_Pulse(Step_Pulse),
      .Aliens_Landed(Aliens_Landed),
      .Ctrl_State(Ctrl_State)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int expv);
      nchk++;
      if (act != expv) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // pixel extents computed alien by alien
   task automatic geom(input logic [49:0] g, output int rmax,
                       output int lmin, output int bmax);
      rmax = -1;
      lmin = 1 << 20;
      bmax = -1;
      for (int i = 0; i < 50; i++) begin
         if (g[i]) begin
            if (m_col + (i % 10) * 40 + 30 > rmax)
               rmax = m_col + (i % 10) * 40 + 30;
            if (m_col + (i % 10) * 40 < lmin)
               lmin = m_col + (i % 10) * 40;
            if (m_row + (i / 10) * 30 + 20 > bmax)
               bmax = m_row + (i / 10) * 30 + 20;
         end
      end
   endtask

   // modes: 0 idle, 1 march, 2 drop, 3 halt
   task automatic model_step(input bit st, input bit tk,
                             input logic [49:0] g, input bit dfd);
      int rmax, lmin, bmax;
      bit upd;
      exp_t e;
      upd = 1'b0;
      geom(g, rmax, lmin, bmax);
      if (st) begin
         m_row = 40; m_col = 100; m_dir = 1;
         m_cnt = 0; m_landed = 0; m_mode = 1;
      end else if (m_mode == 1 || m_mode == 2) begin
         if (dfd) begin
            m_mode = 3;
         end else if (g != 0 && bmax >= 400) begin
            m_mode = 3;
            m_landed = 1;
         end else if (m_mode == 2) begin
            m_row += 10;
            m_dir = 1 - m_dir;
            m_cnt = 0;
            m_mode = 1;
            upd = 1'b1;
         end else if (tk && g != 0) begin
            if (m_cnt + 1 >= 2 + $countones(g) / 2) begin
               m_cnt = 0;
               if (m_dir == 1) begin
                  if (rmax + 10 > 640) m_mode = 2;
                  else begin m_col += 10; upd = 1'b1; end
               end else begin
                  if (lmin < 10) m_mode = 2;
                  else begin m_col -= 10; upd = 1'b1; end
               end
            end else begin
               m_cnt++;
            end
         end
      end
      if (upd) begin
         e.row = 9'(m_row);
         e.col = 10'(m_col);
         e.dir = 1'(m_dir);
         e.st  = 2'(m_mode);
         exp_q.push_back(e);
      end
   endtask

   task automatic cyc(input bit st, input bit tk, input logic [49:0] g);
      Game_Start = st;
      Frame_Tick = tk;
      Aliens_Grid = g;
      Aliens_Defeated = (g == 0);
      model_step(st, tk, g, g == 0);
      @(posedge Clk);
      #1;
      chk("state", int'(Ctrl_State), m_mode);
      chk("dir", int'(Direction), m_dir);
      chk("landed", int'(Aliens_Landed), m_landed);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      #1;
      Reset_N = 1'b0;
      Game_Start = 1'b0;
      Frame_Tick = 1'b0;
      m_row = 40; m_col = 100; m_dir = 1;
      m_cnt = 0; m_landed = 0; m_mode = 0;
      chk("rst_queue", exp_q.size(), 0);
      exp_q.delete();
      #1;
      chk("rst_state", int'(Ctrl_State), 0);
      chk("rst_row", int'(Aliens_Row), 40);
      chk("rst_col", int'(Aliens_Col), 100);
      chk("rst_dir", int'(Direction), 1);
      chk("rst_pulse", int'(Step_Pulse), 0);
      chk("rst_landed", int'(Aliens_Landed), 0);
      @(posedge Clk);
      #1;
      Reset_N = 1'b1;
   endtask

   // monitor: every Step_Pulse must match the next predicted update
   always @(negedge Clk) begin
      if (Reset_N && Step_Pulse) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_row", int'(Aliens_Row), int'(e.row));
            chk("sb_col", int'(Aliens_Col), int'(e.col));
            chk("sb_dir", int'(Direction), int'(e.dir));
            chk("sb_state", int'(Ctrl_State), int'(e.st));
         end
      end
   end

   initial begin
      logic [49:0] g;
      logic [49:0] col0;
      bit st;
      int n;
      col0 = '0;
      for (int r = 0; r < 5; r++) col0[r*10] = 1'b1;

      do_reset();
      repeat (3) cyc(0, 1, FULL);

      // first step after 27 ticks
      cyc(1, 0, FULL);
      for (int i = 0; i < 26; i++) begin
         cyc(0, 1, FULL);
         cyc(0, 0, FULL);
      end
      chk("col_before_step", int'(Aliens_Col), 100);
      chk("no_pulse_early", int'(Step_Pulse), 0);
      cyc(0, 1, FULL);
      chk("col_first_step", int'(Aliens_Col), 110);
      chk("row_first_step", int'(Aliens_Row), 40);
      chk("pulse_first_step", int'(Step_Pulse), 1);

      // march right to 250, then drop
      n = 0;
      while (m_mode != 2 && n < 2000) begin
         cyc(0, 1, FULL);
         n++;
      end
      chk("col_at_edge", int'(Aliens_Col), 250);
      cyc(0, 0, FULL);
      chk("drop_row", int'(Aliens_Row), 50);
      chk("drop_col", int'(Aliens_Col), 250);
      chk("drop_dir", int'(Direction), 0);

      // march down to landing
      n = 0;
      while (m_mode != 3 && n < 40000) begin
         cyc(0, 1, FULL);
         n++;
      end
      chk("land_row", int'(Aliens_Row), 260);
      chk("land_flag", int'(Aliens_Landed), 1);
      repeat (60) cyc(0, 1, FULL);
      chk("halt_row", int'(Aliens_Row), 260);
      chk("halt_col", int'(Aliens_Col), m_col);

      // restart
      cyc(1, 0, FULL);
      chk("restart_row", int'(Aliens_Row), 40);
      chk("restart_col", int'(Aliens_Col), 100);

      // only column 0 alive: bounce right edge, then left edge at col 0
      cyc(1, 0, col0);
      n = 0;
      while (m_row != 60 && n < 5000) begin
         cyc(0, 1, col0);
         n++;
      end
      chk("col0_row", int'(Aliens_Row), 60);
      chk("col0_col", int'(Aliens_Col), 0);
      chk("col0_dir", int'(Direction), 1);

      // kill down to one alien with counter at 5
      cyc(1, 0, FULL);
      repeat (5) cyc(0, 1, FULL);
      cyc(0, 1, 50'd1);
      chk("kill_step_col", int'(Aliens_Col), 110);
      chk("kill_step_pulse", int'(Step_Pulse), 1);

      // defeat then restart
      cyc(0, 1, '0);
      chk("defeat_state", int'(Ctrl_State), 3);
      repeat (5) cyc(0, 1, '0);
      cyc(1, 0, FULL);
      chk("defeat_restart_row", int'(Aliens_Row), 40);
      chk("defeat_restart_col", int'(Aliens_Col), 100);

      // randomized kills, ticks and restarts
      g = FULL;
      for (int k = 0; k < 6000; k++) begin
         st = 1'b0;
         if (m_mode == 3 || $urandom_range(0, 999) == 0) begin
            st = 1'b1;
            g = FULL;
         end else if ($urandom_range(0, 29) == 0) begin
            g[$urandom_range(0, 49)] = 1'b0;
         end
         cyc(st, 1'($urandom_range(0, 1)), g);
      end

      // reset mid-march
      cyc(1, 0, FULL);
      repeat (10) cyc(0, 1, FULL);
      do_reset();
      repeat (40) cyc(0, 1, FULL);
      chk("idle_col", int'(Aliens_Col), 100);

      @(negedge Clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
